// File: rtl/iiitb_riscv.sv
// iiitb_riscv: five-stage (IF, ID, EX, MEM, WB) pipelined 32-bit integer core.
// A custom RISC-V-style encoding runs out of one unified word-addressed memory.
// Operand forwarding, load-use stalling and branch flushing give the pipeline
// the same results as executing the program one instruction at a time.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset; clears PC and all pipeline
//                  registers, but leaves REG and MEM untouched
//   WB1_OUT        MEM/WB result register (the value written back to REG)
//   PC             fetch PC register, word address (MEM is indexed by PC[9:0])
//   EX_MEM_ALUOUT  EX/MEM ALU-result register
//
// REG[0:31] and MEM[0:1023] are plain internal arrays, so benches can preload
// them hierarchically.
module iiitb_riscv (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] WB1_OUT,
  output logic [31:0] PC,
  output logic [31:0] EX_MEM_ALUOUT
);

  localparam logic [6:0] OP_R   = 7'd0;
  localparam logic [6:0] OP_I   = 7'd1;
  localparam logic [6:0] OP_MEM = 7'd2;
  localparam logic [6:0] OP_BR  = 7'd3;

  logic [31:0] REG [0:31];
  logic [31:0] MEM [0:1023];

  // Pipeline registers. A bubble is the all-zero instruction word, which
  // decodes as a write to r0 and therefore has no effect.
  logic [31:0] ifIdInstr_q,  ifIdInstr_d;
  logic [31:0] ifIdPc_q,     ifIdPc_d;
  logic [31:0] idExInstr_q,  idExInstr_d;
  logic [31:0] idExPc_q,     idExPc_d;
  logic [31:0] idExRs1Val_q, idExRs1Val_d;
  logic [31:0] idExRs2Val_q, idExRs2Val_d;
  logic [31:0] idExRdVal_q,  idExRdVal_d;
  logic [31:0] exMemData_q,  exMemData_d;
  logic [4:0]  exMemRd_q,    exMemRd_d;
  logic        exMemAluWr_q, exMemAluWr_d;
  logic        exMemLoad_q,  exMemLoad_d;
  logic        exMemStore_q, exMemStore_d;
  logic [4:0]  memWbRd_q,    memWbRd_d;
  logic        memWbWr_q,    memWbWr_d;
  logic [31:0] pcD, wbOutD, exMemAluOutD;

  // Register read with write-through. r0 always reads as zero, and a register
  // that WB is writing during this cycle returns the new value.
  function automatic logic [31:0] regRead(input logic [4:0] idx, input logic [31:0] arrVal,
                                          input logic wbWr, input logic [4:0] wbRd,
                                          input logic [31:0] wbVal);
    if (idx == 5'd0) return 32'd0;
    if (wbWr && (wbRd == idx)) return wbVal;
    return arrVal;
  endfunction

  // Forwarding into EX. The younger producer (EX/MEM) wins over MEM/WB.
  // Loads sitting in EX/MEM are never forwarded from here: the load-use stall
  // keeps any consumer out of EX until the loaded value has reached MEM/WB.
  function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] idVal,
                                      input logic emWr, input logic [4:0] emRd,
                                      input logic [31:0] emVal, input logic mwWr,
                                      input logic [4:0] mwRd, input logic [31:0] mwVal);
    if (emWr && (emRd == idx)) return emVal;
    if (mwWr && (mwRd == idx)) return mwVal;
    return idVal;
  endfunction

  // ID stage: field decode and register read.
  logic [6:0]  idOp;
  logic [2:0]  idF3;
  logic [4:0]  idRd, idRs1, idRs2;
  logic        idUseRs1, idUseRs2, idUseRd;
  logic [31:0] idRs1Val, idRs2Val, idRdVal;

  assign idOp  = ifIdInstr_q[6:0];
  assign idRd  = ifIdInstr_q[11:7];
  assign idF3  = ifIdInstr_q[14:12];
  assign idRs1 = ifIdInstr_q[19:15];
  assign idRs2 = ifIdInstr_q[24:20];

  assign idRs1Val = regRead(idRs1, REG[idRs1], memWbWr_q, memWbRd_q, WB1_OUT);
  assign idRs2Val = regRead(idRs2, REG[idRs2], memWbWr_q, memWbRd_q, WB1_OUT);
  assign idRdVal  = regRead(idRd,  REG[idRd],  memWbWr_q, memWbRd_q, WB1_OUT);

  // Only the operands an instruction really reads may trigger a load-use stall.
  // The rd field is a source only for a store, where it names the data register.
  assign idUseRs1 = ((idOp == OP_R) && (idF3 <= 3'd5)) || (idOp == OP_I) ||
                    ((idOp == OP_MEM) && (idF3 <= 3'd1)) || ((idOp == OP_BR) && (idF3 <= 3'd1));
  assign idUseRs2 = ((idOp == OP_R) && (idF3 <= 3'd5)) ||
                    ((idOp == OP_MEM) && (idF3 <= 3'd1)) || ((idOp == OP_BR) && (idF3 <= 3'd1));
  assign idUseRd  = (idOp == OP_MEM) && (idF3 == 3'd0);

  // EX stage: operand selection, ALU, address generation and branch decision.
  logic [6:0]  exOp;
  logic [2:0]  exF3;
  logic [4:0]  exRd, exRs1, exRs2;
  logic [31:0] exA, exB, exD, exImmI, exImmB;
  logic [9:0]  exAddr;
  logic [31:0] exAluRes;
  logic        exAluWr, exLoad, exStore, exTaken;

  assign exOp   = idExInstr_q[6:0];
  assign exRd   = idExInstr_q[11:7];
  assign exF3   = idExInstr_q[14:12];
  assign exRs1  = idExInstr_q[19:15];
  assign exRs2  = idExInstr_q[24:20];
  assign exImmI = {{20{idExInstr_q[31]}}, idExInstr_q[31:20]};
  assign exImmB = {{20{idExInstr_q[31]}}, idExInstr_q[31:25], idExInstr_q[11:7]};

  assign exA = fwd(exRs1, idExRs1Val_q, exMemAluWr_q, exMemRd_q, EX_MEM_ALUOUT,
                   memWbWr_q, memWbRd_q, WB1_OUT);
  assign exB = fwd(exRs2, idExRs2Val_q, exMemAluWr_q, exMemRd_q, EX_MEM_ALUOUT,
                   memWbWr_q, memWbRd_q, WB1_OUT);
  assign exD = fwd(exRd,  idExRdVal_q,  exMemAluWr_q, exMemRd_q, EX_MEM_ALUOUT,
                   memWbWr_q, memWbRd_q, WB1_OUT);
  assign exAddr = exA[9:0] + exB[9:0];

  // Writes to r0 never raise a write flag, so r0 is never forwarded or stored.
  // A load into r0 is treated as a non-load for hazard purposes.
  always_comb begin
    exAluRes = 32'd0;
    exAluWr  = 1'b0;
    exLoad   = 1'b0;
    exStore  = 1'b0;
    exTaken  = 1'b0;
    case (exOp)
      OP_R: begin
        case (exF3)
          3'd0: exAluRes = exA + exB;
          3'd1: exAluRes = exA - exB;
          3'd2: exAluRes = exA & exB;
          3'd3: exAluRes = exA | exB;
          3'd4: exAluRes = exA ^ exB;
          3'd5: exAluRes = {31'd0, ($signed(exA) < $signed(exB))};
          default: exAluRes = 32'd0;
        endcase
        exAluWr = (exF3 <= 3'd5) && (exRd != 5'd0);
      end
      OP_I: begin
        case (exF3)
          3'd0: exAluRes = exA + exImmI;
          3'd1: exAluRes = exA - exImmI;
          3'd2: exAluRes = exA & exImmI;
          3'd3: exAluRes = exA | exImmI;
          3'd4: exAluRes = exA ^ exImmI;
          3'd5: exAluRes = {31'd0, ($signed(exA) < $signed(exImmI))};
          3'd6: exAluRes = exA << exImmI[4:0];
          default: exAluRes = exA >> exImmI[4:0];
        endcase
        exAluWr = (exRd != 5'd0);
      end
      OP_MEM: begin
        if (exF3 == 3'd0) begin
          exAluRes = {22'd0, exAddr};
          exStore  = 1'b1;
        end else if (exF3 == 3'd1) begin
          exAluRes = {22'd0, exAddr};
          exLoad   = (exRd != 5'd0);
        end
      end
      OP_BR: begin
        if (exF3 <= 3'd1) begin
          exAluRes = exA - exB;
          exTaken  = (exF3 == 3'd0) ? (exA == exB) : (exA != exB);
        end
      end
      default: exAluRes = 32'd0;
    endcase
  end

  // Next-state for every pipeline register. A taken branch flushes the two
  // younger instructions and redirects fetch; otherwise a load-use hazard
  // holds PC and IF/ID for one cycle and injects a bubble into ID/EX.
  logic stall;

  always_comb begin
    stall = exLoad && ((idUseRs1 && (idRs1 == exRd)) ||
                       (idUseRs2 && (idRs2 == exRd)) ||
                       (idUseRd  && (idRd  == exRd)));

    pcD          = PC + 32'd1;
    ifIdInstr_d  = MEM[PC[9:0]];
    ifIdPc_d     = PC;
    idExInstr_d  = ifIdInstr_q;
    idExPc_d     = ifIdPc_q;
    idExRs1Val_d = idRs1Val;
    idExRs2Val_d = idRs2Val;
    idExRdVal_d  = idRdVal;

    exMemAluOutD = exAluRes;
    exMemData_d  = exD;
    exMemRd_d    = exRd;
    exMemAluWr_d = exAluWr;
    exMemLoad_d  = exLoad;
    exMemStore_d = exStore;

    wbOutD    = exMemLoad_q ? MEM[EX_MEM_ALUOUT[9:0]] : EX_MEM_ALUOUT;
    memWbRd_d = exMemRd_q;
    memWbWr_d = exMemAluWr_q | exMemLoad_q;

    if (exTaken) begin
      pcD          = idExPc_q + exImmB;
      ifIdInstr_d  = 32'd0;
      ifIdPc_d     = 32'd0;
      idExInstr_d  = 32'd0;
      idExPc_d     = 32'd0;
      idExRs1Val_d = 32'd0;
      idExRs2Val_d = 32'd0;
      idExRdVal_d  = 32'd0;
    end else if (stall) begin
      pcD          = PC;
      ifIdInstr_d  = ifIdInstr_q;
      ifIdPc_d     = ifIdPc_q;
      idExInstr_d  = 32'd0;
      idExPc_d     = 32'd0;
      idExRs1Val_d = 32'd0;
      idExRs2Val_d = 32'd0;
      idExRdVal_d  = 32'd0;
    end
  end

  // Pipeline state: reset turns every stage into a bubble and restarts fetch at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PC            <= 32'd0;
      ifIdInstr_q   <= 32'd0;
      ifIdPc_q      <= 32'd0;
      idExInstr_q   <= 32'd0;
      idExPc_q      <= 32'd0;
      idExRs1Val_q  <= 32'd0;
      idExRs2Val_q  <= 32'd0;
      idExRdVal_q   <= 32'd0;
      EX_MEM_ALUOUT <= 32'd0;
      exMemData_q   <= 32'd0;
      exMemRd_q     <= 5'd0;
      exMemAluWr_q  <= 1'b0;
      exMemLoad_q   <= 1'b0;
      exMemStore_q  <= 1'b0;
      WB1_OUT       <= 32'd0;
      memWbRd_q     <= 5'd0;
      memWbWr_q     <= 1'b0;
    end else begin
      PC            <= pcD;
      ifIdInstr_q   <= ifIdInstr_d;
      ifIdPc_q      <= ifIdPc_d;
      idExInstr_q   <= idExInstr_d;
      idExPc_q      <= idExPc_d;
      idExRs1Val_q  <= idExRs1Val_d;
      idExRs2Val_q  <= idExRs2Val_d;
      idExRdVal_q   <= idExRdVal_d;
      EX_MEM_ALUOUT <= exMemAluOutD;
      exMemData_q   <= exMemData_d;
      exMemRd_q     <= exMemRd_d;
      exMemAluWr_q  <= exMemAluWr_d;
      exMemLoad_q   <= exMemLoad_d;
      exMemStore_q  <= exMemStore_d;
      WB1_OUT       <= wbOutD;
      memWbRd_q     <= memWbRd_d;
      memWbWr_q     <= memWbWr_d;
    end
  end

  // Architectural storage is never reset. The write flags are already clear
  // while reset is held, so no write can sneak in during reset.
  always_ff @(posedge clk) begin
    if (memWbWr_q) REG[memWbRd_q] <= WB1_OUT;
  end

  always_ff @(posedge clk) begin
    if (exMemStore_q) MEM[EX_MEM_ALUOUT[9:0]] <= exMemData_q;
  end

endmodule

// File: tb/tb_iiitb_riscv.sv
// Self-checking bench for iiitb_riscv: directed pipeline-timing scenarios
// followed by random programs compared with a sequential instruction-level
// model of the same machine.
module tb_iiitb_riscv;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] WB1_OUT, PC, EX_MEM_ALUOUT;

   int compareCount = 0;
   int failCount    = 0;

   localparam int PROG_LEN  = 40;
   localparam int DATA_BASE = 512;
   localparam int DATA_LEN  = 256;

   logic [31:0] mReg [32];
   logic [31:0] mMem [1024];

   iiitb_riscv dut (
      .clk(clk),
      .rst_n(rst_n),
      .WB1_OUT(WB1_OUT),
      .PC(PC),
      .EX_MEM_ALUOUT(EX_MEM_ALUOUT)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   // One comparison point: every call counts, and a miss is reported and counted.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compareCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Advance n rising edges and settle 1 ns past the last one.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Hold reset and lay down the default machine image: REG[k]=k, MEM all zero.
   task automatic applyStimulus();
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < 1024; i++) dut.MEM[i] = 32'd0;
      for (int k = 0; k < 32; k++) dut.REG[k] = k;
   endtask

   // Release reset between edges so the next rising edge fetches MEM[0].
   task automatic releaseReset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Sequential reference: executes one instruction at a time from the model
   // image until control leaves the program region.
   task automatic runModel(input int len);
      int pc, guard, rd, rs1, rs2, f3, op, immI, immB;
      logic [31:0] ins, a, b, res;
      logic [9:0] addr;
      bit wr;
      pc = 0;
      guard = 0;
      while (pc >= 0 && pc < len && guard < 4096) begin
         guard++;
         ins  = mMem[pc];
         op   = ins[6:0];
         rd   = ins[11:7];
         f3   = ins[14:12];
         rs1  = ins[19:15];
         rs2  = ins[24:20];
         immI = int'($signed(ins[31:20]));
         immB = int'($signed({ins[31:25], ins[11:7]}));
         a    = mReg[rs1];
         b    = mReg[rs2];
         res  = 32'd0;
         wr   = 1'b0;
         pc   = pc + 1;
         if (op == 0 && f3 <= 5) begin
            wr = 1'b1;
            case (f3)
               0: res = a + b;
               1: res = a - b;
               2: res = a & b;
               3: res = a | b;
               4: res = a ^ b;
               default: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            endcase
         end else if (op == 1) begin
            wr = 1'b1;
            case (f3)
               0: res = a + immI;
               1: res = a - immI;
               2: res = a & immI;
               3: res = a | immI;
               4: res = a ^ immI;
               5: res = ($signed(a) < immI) ? 32'd1 : 32'd0;
               6: res = a << (immI % 32 + 32) % 32;
               default: res = a >> (immI % 32 + 32) % 32;
            endcase
         end else if (op == 2) begin
            addr = 10'((a + b) % 1024);
            if (f3 == 0) mMem[addr] = mReg[rd];
            else if (f3 == 1) begin
               wr  = 1'b1;
               res = mMem[addr];
            end
         end else if (op == 3 && f3 <= 1) begin
            if ((f3 == 0) == (a == b)) pc = pc - 1 + immB;
         end
         if (wr && rd != 0) mReg[rd] = res;
      end
   endtask

   initial begin
      logic [31:0] w;
      int kind;
      rst_n = 1'b1;
      #2;

      // ---- Single ADD: pipeline latency and reset state ----
      applyStimulus();
      dut.REG[3] = 32'd0;
      dut.MEM[0] = 32'h00208180;
      checkOutput("reset PC", PC, 32'd0);
      checkOutput("reset WB1_OUT", WB1_OUT, 32'd0);
      checkOutput("reset ALUOUT", EX_MEM_ALUOUT, 32'd0);
      releaseReset();
      tick(1); checkOutput("add PC e1", PC, 32'd1);
      tick(1); checkOutput("add PC e2", PC, 32'd2);
      tick(1); checkOutput("add PC e3", PC, 32'd3);
      checkOutput("add ALUOUT e3", EX_MEM_ALUOUT, 32'd3);
      tick(1); checkOutput("add WB1_OUT e4", WB1_OUT, 32'd3);
      tick(1); checkOutput("add REG3 e5", dut.REG[3], 32'd3);

      // ---- Async reset mid-program cancels the pending write-back ----
      applyStimulus();
      dut.REG[3] = 32'd0;
      dut.MEM[0] = 32'h00208180;
      releaseReset();
      tick(4);
      checkOutput("arst pre WB1_OUT", WB1_OUT, 32'd3);
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput("arst PC", PC, 32'd0);
      checkOutput("arst WB1_OUT", WB1_OUT, 32'd0);
      checkOutput("arst ALUOUT", EX_MEM_ALUOUT, 32'd0);
      tick(2);
      checkOutput("arst REG3 held", dut.REG[3], 32'd0);
      checkOutput("arst MEM0 held", dut.MEM[0], 32'h00208180);
      releaseReset();
      tick(1); checkOutput("arst restart PC", PC, 32'd1);
      tick(4); checkOutput("arst restart REG3", dut.REG[3], 32'd3);

      // ---- Forwarding without stalls ----
      applyStimulus();
      dut.REG[3] = 32'd0; dut.REG[4] = 32'd0; dut.REG[5] = 32'd0;
      dut.MEM[0] = 32'h00208180;
      dut.MEM[1] = 32'h00318280;
      dut.MEM[2] = 32'h00208201;
      dut.MEM[3] = 32'h0020E201;
      releaseReset();
      tick(4);
      checkOutput("fwd PC e4", PC, 32'd4);
      checkOutput("fwd ALUOUT add r5", EX_MEM_ALUOUT, 32'd6);
      tick(1); checkOutput("fwd ALUOUT addi", EX_MEM_ALUOUT, 32'd3);
      tick(1); checkOutput("fwd ALUOUT slli", EX_MEM_ALUOUT, 32'd4);
      tick(2);
      checkOutput("fwd PC e8", PC, 32'd8);
      checkOutput("fwd REG5", dut.REG[5], 32'd6);
      checkOutput("fwd REG4", dut.REG[4], 32'd4);

      // ---- Store, load and a load-use stall ----
      applyStimulus();
      dut.REG[7] = 32'd0; dut.REG[8] = 32'd0;
      dut.MEM[0] = 32'h00520302;
      dut.MEM[1] = 32'h00521382;
      dut.MEM[2] = 32'h00138400;
      releaseReset();
      tick(3);
      checkOutput("mem PC e3", PC, 32'd3);
      checkOutput("mem store addr", EX_MEM_ALUOUT, 32'd9);
      tick(1); checkOutput("mem PC stall e4", PC, 32'd3);
      tick(1); checkOutput("mem PC e5", PC, 32'd4);
      tick(6);
      checkOutput("mem MEM9", dut.MEM[9], 32'd6);
      checkOutput("mem REG7", dut.REG[7], 32'd6);
      checkOutput("mem REG8", dut.REG[8], 32'd7);

      // ---- Taken branch flushes the two following instructions ----
      applyStimulus();
      dut.REG[9] = 32'hAA; dut.REG[3] = 32'd0;
      dut.MEM[5]  = 32'h00210603;
      dut.MEM[6]  = 32'h00108480;
      dut.MEM[7]  = 32'h00108480;
      dut.MEM[17] = 32'h00208180;
      releaseReset();
      tick(7); checkOutput("beq PC e7", PC, 32'd7);
      tick(1); checkOutput("beq PC target", PC, 32'd17);
      tick(10);
      checkOutput("beq REG9 untouched", dut.REG[9], 32'hAA);
      checkOutput("beq REG3 at target", dut.REG[3], 32'd3);

      // ---- Not-taken branch falls through ----
      applyStimulus();
      dut.REG[9] = 32'hAA;
      dut.MEM[5] = 32'h00310603;
      dut.MEM[6] = 32'h00108480;
      releaseReset();
      tick(8);
      checkOutput("bnt PC e8", PC, 32'd8);
      checkOutput("bnt ALUOUT r2-r3", EX_MEM_ALUOUT, 32'hFFFF_FFFF);
      tick(6); checkOutput("bnt REG9", dut.REG[9], 32'd2);

      // ---- Writes to r0 are discarded and never forwarded ----
      applyStimulus();
      dut.REG[10] = 32'd0;
      dut.MEM[0] = 32'h00208000;
      dut.MEM[1] = 32'h00100500;
      releaseReset();
      tick(3); checkOutput("r0 ALUOUT", EX_MEM_ALUOUT, 32'd3);
      tick(1); checkOutput("r0 read ALUOUT", EX_MEM_ALUOUT, 32'd1);
      tick(4);
      checkOutput("r0 REG0", dut.REG[0], 32'd0);
      checkOutput("r0 REG10", dut.REG[10], 32'd1);

      // ---- Random programs against the sequential model ----
      // r20..r23 are read-only base registers keeping every data access in
      // MEM[512..767], well away from the code that is fetched.
      for (int iter = 0; iter < 4; iter++) begin
         applyStimulus();
         for (int k = 0; k < 32; k++) mReg[k] = $urandom;
         mReg[0] = 32'd0;
         for (int k = 20; k < 24; k++) mReg[k] = 32'($urandom_range(256, 383));
         for (int i = 0; i < 1024; i++) mMem[i] = 32'd0;
         for (int i = DATA_BASE; i < DATA_BASE + DATA_LEN; i++) mMem[i] = $urandom;
         for (int i = 0; i < PROG_LEN; i++) begin
            w = $urandom;
            kind = $urandom_range(0, 19);
            if (kind < 7) begin
               w[6:0] = 7'd0;  w[14:12] = 3'($urandom_range(0, 5));
               w[11:7] = 5'($urandom_range(0, 15));
               w[19:15] = 5'($urandom_range(0, 23)); w[24:20] = 5'($urandom_range(0, 23));
            end else if (kind < 12) begin
               w[6:0] = 7'd1;  w[14:12] = 3'($urandom_range(0, 7));
               w[11:7] = 5'($urandom_range(0, 15)); w[19:15] = 5'($urandom_range(0, 23));
            end else if (kind < 16) begin
               w[6:0] = 7'd2;  w[14:12] = 3'($urandom_range(0, 2));
               w[11:7] = 5'($urandom_range(0, 15));
               w[19:15] = 5'($urandom_range(20, 21)); w[24:20] = 5'($urandom_range(22, 23));
            end else if (kind < 18) begin
               w[6:0] = 7'd3;  w[14:12] = 3'($urandom_range(0, 2));
               w[19:15] = 5'($urandom_range(1, 23));
               w[24:20] = ($urandom_range(0, 1) == 0) ? w[19:15] : 5'($urandom_range(0, 23));
               w[31:25] = 7'd0; w[11:7] = 5'($urandom_range(1, 3));
            end else begin
               w[6:0] = 7'($urandom_range(4, 127));
            end
            mMem[i] = w;
         end
         for (int k = 0; k < 32; k++) dut.REG[k] = mReg[k];
         for (int i = 0; i < 1024; i++) dut.MEM[i] = mMem[i];
         runModel(PROG_LEN);
         releaseReset();
         tick(3 * PROG_LEN + 20);
         for (int k = 0; k < 32; k++)
            checkOutput($sformatf("rand%0d REG[%0d]", iter, k), dut.REG[k], mReg[k]);
         for (int i = DATA_BASE; i < DATA_BASE + DATA_LEN; i++)
            checkOutput($sformatf("rand%0d MEM[%0d]", iter, i), dut.MEM[i], mMem[i]);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $finish;
   end

endmodule

// File: doc/iiitb_riscv.md
# iiitb_riscv

Five-stage pipelined 32-bit integer core (IF, ID, EX, MEM, WB) with a custom RISC-V-style encoding and one unified word-addressed memory for instructions and data. It is the top-level processor block; benches preload its register file and memory hierarchically and observe the fetch PC, the EX/MEM ALU result and the write-back value. Operand forwarding, load-use stalling and branch flushing give sequential-program semantics.

## Interface
- No parameters. Fixed sizes: REG[0:31] 32-bit register file; MEM[0:1023] 32-bit memory. Both are internal arrays named exactly REG and MEM and must be reachable hierarchically.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset. One clock; reset is asynchronous and active-low.
- WB1_OUT  output  32  MEM/WB result register: the value the WB stage writes to the register file.
- PC  output  32  fetch PC register, word address. It is driven directly by the internal reg PC, which benches may also poke.
- EX_MEM_ALUOUT  output  32  EX/MEM ALU-result register.

## Operation
- Fields: opcode [6:0], rd [11:7], funct3 [14:12], rs1 [19:15], rs2 [24:20].
- immI = sext(instr[31:20]).
- immB = sext({instr[31:25], instr[11:7]}), 12 bits, offset counted in words.
- Opcode 0 (R-type), rd ← f(rs1, rs2) by funct3: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed, result 1/0).
- Opcode 1 (I-type), rd ← f(rs1, immI) by funct3: 0 ADDI, 1 SUBI, 2 ANDI, 3 ORI, 4 XORI, 5 SLTI, 6 SLLI, 7 SRLI. Shift amount is immI[4:0].
- Opcode 2 (memory). Address = (REG[rs1] + REG[rs2])[9:0]; the rd field names the data register.
  - funct3 0 STORE: MEM[addr] ← REG[rd].
  - funct3 1 LOAD: REG[rd] ← MEM[addr].
  - Other funct3 values: NOP.
- Opcode 3 (branch). funct3 0 BEQ, 1 BNE. Target = branch PC + immB. Other funct3 values: NOP.
- All other opcodes: NOP, with no register or memory write.
- Register 0 is hardwired zero; writes to it are discarded. The all-zero word therefore executes as a NOP.
- EX_MEM_ALUOUT contents:
  - R-type and I-type: the result.
  - Memory ops: the address.
  - Branches: rs1 − rs2.
  - Bubbles: 0.
- Memory is unified. A store to an address that is fetched later is visible to that fetch.

## Timing
- IF: instruction MEM[PC] is latched into IF/ID; PC ← PC+1.
- ID: register read, with write-through (a read of the register WB writes this cycle returns the new value).
- EX: ALU, branch decision, forwarding.
- MEM: store write happens at the clock edge; load read is combinational and latched into MEM/WB.
- WB: REG[rd] ← WB1_OUT at the edge after MEM/WB is loaded.
- Counted from the edge that fetches an instruction (edge 1):
  - Edge 3: EX_MEM_ALUOUT holds its ALU result.
  - Edge 4: WB1_OUT holds its result.
  - Edge 5: REG is updated.
- Forwarding into EX: priority is EX/MEM, then MEM/WB, then the ID-read value. No stall occurs for ALU→ALU dependencies.
- Load-use: if a LOAD in EX has an rd that matches rs1/rs2/rd-data of the instruction in ID, stall one cycle. During the stall, PC and IF/ID hold and a bubble enters ID/EX; the value is then forwarded from MEM/WB.
- Taken branch, resolved in EX: PC ← target at that edge, and IF/ID and ID/EX are flushed to bubbles (2-cycle penalty). Not-taken branches cost nothing.
- Stall and taken branch in the same cycle: the branch wins.
- Reset (rst_n low, async, any time, including mid-program):
  - PC = 0.
  - All pipeline registers become bubbles.
  - WB1_OUT = 0 and EX_MEM_ALUOUT = 0 immediately.
  - REG and MEM are not modified.
  - The first fetch, MEM[0], happens on the first rising edge after rst_n goes high.
- PC wraps modulo 2^32; MEM is indexed by PC[9:0].

## Test plan
- Preload REG[k]=k and MEM[0]=0x00208180 (add r3,r1,r2), rest 0; release reset. Required: PC reads 1, 2, 3 after edges 1–3; EX_MEM_ALUOUT=3 after edge 3; WB1_OUT=3 after edge 4; REG[3]=3.
- Forwarding. Program: MEM[0]=0x00208180, MEM[1]=0x00318280 (add r5,r3,r3), MEM[2]=0x00208201 (addi r4,r1,2), MEM[3]=0x0020E201 (slli r4,r1,2). Required: REG[5]=6, REG[4]=4, with no stall cycles.
- Memory. Setup: REG[4]=4, REG[5]=5, REG[6]=6. Program: 0x00520302 (store), 0x00521382 (load r7), 0x00138400 (add r8,r7,r1). Required:
  - MEM[9]=6 and REG[7]=6.
  - One stall, during which PC holds for one cycle.
  - REG[8]=7.
- Branch at MEM[5] with target MEM[17]=0x00208180.
  - Taken: MEM[5]=0x00210603 (beq r2,r2,+12) → PC=17; MEM[6] and MEM[7] set to add r9,r1,r1 never write r9.
  - Not taken: beq r2,r3 falls through to MEM[6].
- Async reset. Drop rst_n mid-program between clock edges. Required: PC, WB1_OUT and EX_MEM_ALUOUT are 0 immediately; REG and MEM are unchanged; after release the program restarts at MEM[0].
- Writes to r0 (e.g. add r0,r1,r2) → REG[0] stays 0, and later reads of r0 return 0.
